// File: rtl/c17_pkg.sv
// Shared types and per-level logic for the pipelined c17 core.
// Each stage payload is one record per lane; the top builds packed arrays of them.
package c17_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;

  // Signals still needed by later levels once L1 has been evaluated
  typedef struct packed {
    logic net_0;
    logic net_1;
    logic nx2;
    logic nx7;
  } c17_l1_t;

  typedef struct packed {
    logic net_0;
    logic net_2;
    logic net_3;
  } c17_l2_t;

  typedef struct packed {
    logic nx22;
    logic nx23;
  } c17_l3_t;

  function automatic c17_l1_t c17_l1(input logic nx1, input logic nx2, input logic nx3,
                                     input logic nx6, input logic nx7);
    c17_l1_t r;
    r.net_0 = ~(nx1 & nx3);
    r.net_1 = ~(nx3 & nx6);
    r.nx2   = nx2;
    r.nx7   = nx7;
    return r;
  endfunction

  function automatic c17_l2_t c17_l2(input c17_l1_t a);
    c17_l2_t r;
    r.net_0 = a.net_0;
    r.net_2 = ~(a.nx7 & a.net_1);
    r.net_3 = ~(a.nx2 & a.net_1);
    return r;
  endfunction

  function automatic c17_l3_t c17_l3(input c17_l2_t a);
    c17_l3_t r;
    r.nx22 = ~(a.net_0 & a.net_3);
    r.nx23 = ~(a.net_3 & a.net_2);
    return r;
  endfunction

endpackage

// File: rtl/c17_pipe_stage.sv
// One valid/ready pipeline register. An empty slot always accepts, so bubbles collapse.
module c17_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load on transfer, otherwise hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/c17_pipe.sv
// Multi-lane c17 with 1-3 handshaked register stages and a saturating
// output-handshake counter.
module c17_pipe
  import c17_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] nx1,
  input  logic [LANES-1:0] nx2,
  input  logic [LANES-1:0] nx3,
  input  logic [LANES-1:0] nx6,
  input  logic [LANES-1:0] nx7,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] nx22,
  output logic [LANES-1:0] nx23,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int W1 = LANES * $bits(c17_l1_t);
  localparam int W2 = LANES * $bits(c17_l2_t);
  localparam int W3 = LANES * $bits(c17_l3_t);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  c17_l1_t [LANES-1:0] l1_s;
  c17_l3_t [LANES-1:0] out_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // First logic level straight from the primary inputs
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      l1_s[i] = c17_l1(nx1[i], nx2[i], nx3[i], nx6[i], nx7[i]);
    end
  end

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad
    $error("c17_pipe: STAGES must be 1, 2 or 3");
  end

  if (STAGES == 3) begin : g_s3
    c17_l1_t [LANES-1:0] s0_s;
    c17_l2_t [LANES-1:0] l2_s, s1_s;
    c17_l3_t [LANES-1:0] l3_s;
    logic v0_s, v1_s, r1_s, r2_s;

    c17_pipe_stage #(.W(W1)) u_st0 (
      .clk(clk), .rst_n(rst_n), .valid_i(in_valid), .data_i(l1_s), .ready_o(in_ready),
      .valid_o(v0_s), .data_o(s0_s), .ready_i(r1_s));

    always_comb begin
      for (int i = 0; i < LANES; i++) l2_s[i] = c17_l2(s0_s[i]);
    end

    c17_pipe_stage #(.W(W2)) u_st1 (
      .clk(clk), .rst_n(rst_n), .valid_i(v0_s), .data_i(l2_s), .ready_o(r1_s),
      .valid_o(v1_s), .data_o(s1_s), .ready_i(r2_s));

    always_comb begin
      for (int i = 0; i < LANES; i++) l3_s[i] = c17_l3(s1_s[i]);
    end

    c17_pipe_stage #(.W(W3)) u_st2 (
      .clk(clk), .rst_n(rst_n), .valid_i(v1_s), .data_i(l3_s), .ready_o(r2_s),
      .valid_o(out_valid), .data_o(out_s), .ready_i(out_ready));
  end else if (STAGES == 2) begin : g_s2
    c17_l1_t [LANES-1:0] s0_s;
    c17_l3_t [LANES-1:0] l3_s;
    logic v0_s, r1_s;

    c17_pipe_stage #(.W(W1)) u_st0 (
      .clk(clk), .rst_n(rst_n), .valid_i(in_valid), .data_i(l1_s), .ready_o(in_ready),
      .valid_o(v0_s), .data_o(s0_s), .ready_i(r1_s));

    always_comb begin
      for (int i = 0; i < LANES; i++) l3_s[i] = c17_l3(c17_l2(s0_s[i]));
    end

    c17_pipe_stage #(.W(W3)) u_st1 (
      .clk(clk), .rst_n(rst_n), .valid_i(v0_s), .data_i(l3_s), .ready_o(r1_s),
      .valid_o(out_valid), .data_o(out_s), .ready_i(out_ready));
  end else if (STAGES == 1) begin : g_s1
    c17_l3_t [LANES-1:0] l3_s;

    always_comb begin
      for (int i = 0; i < LANES; i++) l3_s[i] = c17_l3(c17_l2(l1_s[i]));
    end

    c17_pipe_stage #(.W(W3)) u_st0 (
      .clk(clk), .rst_n(rst_n), .valid_i(in_valid), .data_i(l3_s), .ready_o(in_ready),
      .valid_o(out_valid), .data_o(out_s), .ready_i(out_ready));
  end

  // Unpack the final stage into the per-lane output buses
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      nx22[i] = out_s[i].nx22;
      nx23[i] = out_s[i].nx23;
    end
  end

  // Clear wins over a same-cycle handshake; count sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Transaction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;

endmodule

// File: tb/tb_c17_pipe.sv
// Bench for c17_pipe: five instances (STAGES 3/2/1, CNT_W=2, LANES=1) against a queue model.
module tb_c17_pipe;

  localparam int NDUT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;
  logic clr_cnt = 1'b0;
  logic [3:0]  x1 [NDUT];
  logic [3:0]  x2 [NDUT];
  logic [3:0]  x3 [NDUT];
  logic [3:0]  x6 [NDUT];
  logic [3:0]  x7 [NDUT];
  logic        iv [NDUT];
  logic        ir [NDUT];
  logic        ov [NDUT];
  logic [3:0]  o22 [NDUT];
  logic [3:0]  o23 [NDUT];
  logic [15:0] cnt [NDUT];
  logic        l1_22, l1_23;
  logic [1:0]  c2_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c17_pipe #(.LANES(4), .STAGES(3), .CNT_W(16)) u_s3 (
    .clk(clk), .rst_n(rst_n), .nx1(x1[0]), .nx2(x2[0]), .nx3(x3[0]), .nx6(x6[0]), .nx7(x7[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .nx22(o22[0]), .nx23(o23[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .out_cnt(cnt[0]));
  c17_pipe #(.LANES(4), .STAGES(2), .CNT_W(16)) u_s2 (
    .clk(clk), .rst_n(rst_n), .nx1(x1[1]), .nx2(x2[1]), .nx3(x3[1]), .nx6(x6[1]), .nx7(x7[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .nx22(o22[1]), .nx23(o23[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .out_cnt(cnt[1]));
  c17_pipe #(.LANES(4), .STAGES(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst_n(rst_n), .nx1(x1[2]), .nx2(x2[2]), .nx3(x3[2]), .nx6(x6[2]), .nx7(x7[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .nx22(o22[2]), .nx23(o23[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .out_cnt(cnt[2]));
  c17_pipe #(.LANES(4), .STAGES(3), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .nx1(x1[3]), .nx2(x2[3]), .nx3(x3[3]), .nx6(x6[3]), .nx7(x7[3]),
    .in_valid(iv[3]), .in_ready(ir[3]), .nx22(o22[3]), .nx23(o23[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .out_cnt(c2_cnt));
  c17_pipe #(.LANES(1), .STAGES(3), .CNT_W(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .nx1(x1[4][0:0]), .nx2(x2[4][0:0]), .nx3(x3[4][0:0]),
    .nx6(x6[4][0:0]), .nx7(x7[4][0:0]), .in_valid(iv[4]), .in_ready(ir[4]), .nx22(l1_22),
    .nx23(l1_23), .out_valid(ov[4]), .out_ready(out_ready), .clr_cnt(clr_cnt), .out_cnt(cnt[4]));

  assign cnt[3] = {14'd0, c2_cnt};
  assign o22[4] = {3'b000, l1_22};
  assign o23[4] = {3'b000, l1_23};

  function automatic int stg_of(input int d);
    case (d)
      1: return 2;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 3) ? 3 : 65535;
  endfunction

  function automatic logic [3:0] mask_of(input int d);
    return (d == 4) ? 4'b0001 : 4'b1111;
  endfunction

  // Reference: the six NANDs of c17, whole word at once; result {nx22, nx23}
  function automatic logic [7:0] c17_ref(input logic [19:0] w);
    logic [3:0] a, b, c, f, g, n0, n1, n2, n3;
    {a, b, c, f, g} = w;
    n0 = ~(a & c);
    n1 = ~(c & f);
    n2 = ~(g & n1);
    n3 = ~(b & n1);
    return {~(n0 & n3), ~(n3 & n2)};
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Scoreboard: expected-word queue and handshake counter per instance
  logic [7:0] sbq [NDUT][$];
  int mcnt [NDUT];
  int popped [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      mcnt[d] = 0;
      popped[d] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < NDUT; d++) begin
          sbq[d].delete();
          mcnt[d] = 0;
        end
      end else begin
        for (int d = 0; d < NDUT; d++) begin
          chk("cnt_track", d, {16'd0, cnt[d]}, mcnt[d]);
          if (ov[d] && out_ready) begin
            popped[d]++;
            if (sbq[d].size() == 0) begin
              chk("dup_word", d, 32'd1, 32'd0);
            end else begin
              chk("out_word", d, {24'd0, o22[d], o23[d]}, {24'd0, sbq[d].pop_front()});
            end
          end
          if (iv[d] && ir[d])
            sbq[d].push_back(c17_ref({x1[d], x2[d], x3[d], x6[d], x7[d]}) & {mask_of(d), mask_of(d)});
          if (clr_cnt) mcnt[d] = 0;
          else if (ov[d] && out_ready && mcnt[d] < cmax_of(d)) mcnt[d]++;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] x1, x2, x3, x6, x7, e22, e23;
  } vec_t;
  vec_t tv [5];

  task automatic drive_word(input int d, input logic [19:0] w);
    {x1[d], x2[d], x3[d], x6[d], x7[d]} = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) iv[d] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One word into every instance; latency and value checked against the table
  task automatic send_one(input int vi);
    bit seen [NDUT];
    @(negedge clk);
    out_ready = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      drive_word(d, {tv[vi].x1, tv[vi].x2, tv[vi].x3, tv[vi].x6, tv[vi].x7});
      iv[d] = 1'b1;
      seen[d] = 1'b0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) iv[d] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < NDUT; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          chk("latency", d, k, stg_of(d) - 1);
          chk("vec_nx22", d, {28'd0, o22[d]}, {28'd0, tv[vi].e22 & mask_of(d)});
          chk("vec_nx23", d, {28'd0, o23[d]}, {28'd0, tv[vi].e23 & mask_of(d)});
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < NDUT; d++) chk("vec_seen", d, {31'd0, seen[d]}, 32'd1);
  endtask

  // Streams n words per instance; rnd toggles in_valid/out_ready, else a stall window
  bit saw_low [NDUT];
  logic [19:0] words [$];

  task automatic run_stream(input int n, input bit rnd, input int budget);
    int sent [NDUT];
    bit will [NDUT];
    bit done;
    int cyc;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(20'($urandom));
    for (int d = 0; d < NDUT; d++) begin
      sent[d] = 0;
      will[d] = 1'b0;
      saw_low[d] = 1'b0;
      popped[d] = 0;
    end
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (will[d]) begin
          sent[d]++;
          iv[d] = 1'b0;
          will[d] = 1'b0;
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(cyc >= 30 && cyc < 35);
      for (int d = 0; d < NDUT; d++) begin
        if (!iv[d] && sent[d] < n && (!rnd || $urandom_range(0, 1) == 1)) begin
          iv[d] = 1'b1;
          drive_word(d, words[sent[d]]);
        end
      end
      #1;
      done = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        will[d] = iv[d] & ir[d];
        if (!out_ready && !ir[d]) saw_low[d] = 1'b1;
        if (sent[d] < n || iv[d] || sbq[d].size() != 0) done = 1'b0;
      end
      cyc++;
    end
    chk("stream_timeout", 0, {31'd0, done}, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    tv[0] = '{x1: 4'hF, x2: 4'hF, x3: 4'hF, x6: 4'hF, x7: 4'hF, e22: 4'hF, e23: 4'h0};
    tv[1] = '{x1: 4'h0, x2: 4'h0, x3: 4'h0, x6: 4'h0, x7: 4'h0, e22: 4'h0, e23: 4'h0};
    tv[2] = '{x1: 4'hF, x2: 4'hF, x3: 4'hF, x6: 4'h0, x7: 4'h0, e22: 4'hF, e23: 4'hF};
    tv[3] = '{x1: 4'hD, x2: 4'hD, x3: 4'hD, x6: 4'h1, x7: 4'h1, e22: 4'hD, e23: 4'hC};
    tv[4] = '{x1: 4'h0, x2: 4'hF, x3: 4'hF, x6: 4'h0, x7: 4'hF, e22: 4'hF, e23: 4'hF};
    for (int d = 0; d < NDUT; d++) begin
      drive_word(d, 20'd0);
      iv[d] = 1'b0;
    end

    #7;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_out_valid", d, {31'd0, ov[d]}, 32'd0);
      chk("rst_in_ready", d, {31'd0, ir[d]}, 32'd1);
      chk("rst_out_cnt", d, {16'd0, cnt[d]}, 32'd0);
      chk("rst_nx22_nx23", d, {24'd0, o22[d], o23[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; five handshakes also saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send_one(i);
      for (int d = 0; d < NDUT; d++)
        chk("vec_cnt", d, {16'd0, cnt[d]}, (i + 1 < cmax_of(d)) ? i + 1 : cmax_of(d));
    end

    // Clear coinciding with an output handshake
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      drive_word(d, {tv[0].x1, tv[0].x2, tv[0].x3, tv[0].x6, tv[0].x7});
      iv[d] = 1'b1;
    end
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) iv[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) chk("held_valid", d, {31'd0, ov[d]}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    for (int d = 0; d < NDUT; d++) chk("clr_wins", d, {16'd0, cnt[d]}, 32'd0);

    // Reset with words in flight
    send_one(2);
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      drive_word(d, {tv[2].x1, tv[2].x2, tv[2].x3, tv[2].x6, tv[2].x7});
      iv[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      iv[d] = 1'b0;
      chk("pre_rst_cnt", d, {16'd0, cnt[d]}, 32'd1);
      chk("pre_rst_valid", d, {31'd0, ov[d]}, 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("async_rst_valid", d, {31'd0, ov[d]}, 32'd0);
      chk("async_rst_cnt", d, {16'd0, cnt[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_one(0);
    for (int d = 0; d < NDUT; d++) chk("post_rst_cnt", d, {16'd0, cnt[d]}, 32'd1);

    // 100 words with a 5-cycle sink stall
    do_reset();
    run_stream(100, 1'b0, 1000);
    for (int d = 0; d < NDUT; d++) begin
      chk("stall_in_ready_low", d, {31'd0, saw_low[d]}, 32'd1);
      chk("stream_emitted", d, popped[d], 100);
      chk("stream_cnt", d, {16'd0, cnt[d]}, (d == 3) ? 3 : 100);
    end

    // Random handshake toggling
    do_reset();
    run_stream(2000, 1'b1, 10000);
    for (int d = 0; d < NDUT; d++) begin
      chk("rand_emitted", d, popped[d], 2000);
      chk("rand_cnt", d, {16'd0, cnt[d]}, (d == 3) ? 3 : 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c17_pipe.md
# c17_pipe

Parametrised, pipelined successor to the c17 NAND benchmark core. Evaluates the same six-NAND c17 function bitwise across `LANES` independent lanes, with 1–3 register stages inserted between logic levels and a valid/ready handshake per stage. Adds a saturating output-transaction counter. It sits in the benchmark suite as the sequential c17 variant, used to exercise register-to-register slack under backpressure.

## Interface
- `LANES`, 4: bit-slices evaluated in parallel, ≥1
- `STAGES`, 3: register stages, legal values 1, 2, 3; any other value is an elaboration error
- `CNT_W`, 16: width of the transaction counter, ≥2

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `nx1`, `nx2`, `nx3`, `nx6`, `nx7`  in  LANES  per-lane c17 primary inputs
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  pipeline accepts the word this cycle
- `nx22`, `nx23`  out  LANES  per-lane c17 outputs, registered
- `out_valid`  out  1  `nx22`/`nx23` valid
- `out_ready`  in  1  sink accepts output
- `clr_cnt`  in  1  synchronous clear of `out_cnt`
- `out_cnt`  out  CNT_W  number of completed output handshakes, saturating

## Operation
- Logic levels, bitwise per lane:
  - L1: `net_0 = ~(nx1 & nx3)`, `net_1 = ~(nx3 & nx6)`
  - L2: `net_2 = ~(nx7 & net_1)`, `net_3 = ~(nx2 & net_1)`
  - L3: `nx22 = ~(net_0 & net_3)`, `nx23 = ~(net_3 & net_2)`
- Register placement:
  - STAGES=3: after L1, L2 and L3.
  - STAGES=2: after L1 and L3.
  - STAGES=1: after L3 only.
- A stage carries only the signals later levels need:
  - After L1: `net_0`, `net_1`, `nx2`, `nx7`.
  - After L2: `net_0`, `net_2`, `net_3`.
- Handshake:
  - Each stage k holds a `valid_k` bit.
  - `ready_k = ~valid_k | ready_{k+1}`, with the last stage's downstream ready = `out_ready`.
  - `in_ready = ready_0`.
  - A transfer occurs on a cycle where both valid and ready are high.
- Data is held unchanged in a stage while it is valid and not ready. No word is dropped or duplicated.
- Bubbles collapse: an empty stage accepts even when the downstream stage is stalled.
- Counter behaviour:
  - `out_cnt` increments on each `out_valid & out_ready`.
  - It saturates at 2^CNT_W−1.
  - `clr_cnt` takes priority: clear and handshake in the same cycle gives `out_cnt` = 0, and that handshake is not counted.
- `in_valid` while `in_ready` = 0: the word is ignored. The source must hold it.

## Timing
- Reset (asynchronous assert): all `valid_k` = 0, all stage data = 0, `nx22` = `nx23` = 0, `out_valid` = 0, `out_cnt` = 0, `in_ready` = 1.
- Reset mid-operation discards all in-flight words. The first post-reset handshake uses a clean pipeline.
- Latency: a word accepted at edge t is presented on `nx22`/`nx23` with `out_valid` = 1 after edge t+STAGES−1, i.e. STAGES cycles from acceptance to first visible output, with no stall.
- Throughput: 1 word/cycle when `out_ready` is held at 1.
- A full pipeline with simultaneous emit and accept sustains 1 word/cycle, with no bubble.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 combinationally in the same cycle.
- `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.

## Structure
- Package `c17_pkg`:
  - the legal STAGES range constants;
  - packed struct typedefs for the L1 and L2 stage payloads;
  - the pure per-level functions `c17_l1`, `c17_l2`, `c17_l3`.
- Sub-module `c17_pipe_stage`, parametrised on payload width: valid/data register plus ready computation. It is instantiated STAGES times via generate, selected by STAGES.
- The counter is inline in the top.

## Test plan
- LANES=1, STAGES=3, `out_ready` = 1, inputs all 1 → after 3 cycles `nx22` = 1, `nx23` = 0, `out_valid` = 1, `out_cnt` = 1.
- All inputs 0 → `nx22` = 0, `nx23` = 0. Inputs nx1=1, nx3=1, nx2=1, nx6=0, nx7=0 → `nx22` = 1, `nx23` = 1. Check for every STAGES in {1, 2, 3}, with latency equal to STAGES.
- LANES=4, streaming 100 random words: hold `out_ready` = 0 for 5 cycles mid-stream → `in_ready` drops after the pipeline fills, no loss or duplication, order preserved versus the reference model, `out_cnt` = 100.
- Reset asserted with 3 words in flight → `out_valid` and `out_cnt` go to 0 immediately. After release, a new word emerges with the correct latency.
- CNT_W=2: run 5 handshakes → `out_cnt` = 3, saturated. Assert `clr_cnt` during a handshake → `out_cnt` = 0.
- Random `in_valid`/`out_ready` toggling for 10k cycles → every accepted word is emitted exactly once with correct values.
